// File: rtl/helai_sync_fifo.sv
// helai_sync_fifo: single-clock FIFO with fall-through or registered read, programmable
// almost-full/almost-empty levels, occupancy count, flush and sticky overflow/underflow.
module helai_sync_fifo #(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = "TRUE",
    parameter string TYPE        = "distributed",
    parameter int    AW_LEVEL    = 2**ASIZE-1,
    parameter int    AR_LEVEL    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);
    localparam int DEPTH = 2**ASIZE;
    localparam bit FWFT  = FALLTHROUGH == "TRUE";
    localparam bit PF    = FWFT && TYPE == "block";

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_waddr, r_raddr;
    logic [ASIZE:0]   r_count;
    logic [DSIZE-1:0] r_rdata;
    logic             r_pf_valid, r_overflow, r_underflow;
    logic             w_run, w_wr, w_rd, w_fetch, w_radv;
    logic [ASIZE:0]   w_ram_cnt;

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign wfull     = r_count == (ASIZE+1)'(DEPTH);
    assign awfull    = r_count >= (ASIZE+1)'(AW_LEVEL);
    assign arempty   = r_count <= (ASIZE+1)'(AR_LEVEL);
    assign rempty    = PF ? !r_pf_valid : r_count == '0;
    assign rdata     = (FWFT && !PF) ? (rempty ? '0 : r_mem[r_raddr]) : r_rdata;

    assign w_run     = !rst && !flush;
    assign w_wr      = w_run && winc && !wfull;
    assign w_rd      = w_run && rinc && !rempty;
    // RAM occupancy excludes the word already parked in the prefetch register
    assign w_ram_cnt = r_count - {{ASIZE{1'b0}}, r_pf_valid};
    assign w_fetch   = w_run && (!r_pf_valid || w_rd) && w_ram_cnt != '0;
    assign w_radv    = PF ? w_fetch : w_rd;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_count     <= '0;
            r_rdata     <= '0;
            r_pf_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_waddr    <= r_waddr + ASIZE'(w_wr);
            r_raddr    <= r_raddr + ASIZE'(w_radv);
            r_count    <= r_count + (ASIZE+1)'(w_wr) - (ASIZE+1)'(w_rd);
            r_pf_valid <= PF && (w_fetch || (r_pf_valid && !w_rd));
            if (PF ? w_fetch : (!FWFT && w_rd))
                r_rdata <= r_mem[r_raddr];
            if (winc && wfull)
                r_overflow <= 1'b1;
            if (rinc && rempty)
                r_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_helai_sync_fifo.sv
// tb_helai_sync_fifo: directed checks of three FIFO configurations, one at a time.
module tb_helai_sync_fifo;
    logic       clk = 0, rst = 1, flush = 0, winc = 0, rinc = 0;
    logic [7:0] wdata = 0;
    logic [2:0] we, rs;
    logic [7:0] rd [3];
    logic [4:0] cnt [3];
    logic       wf [3], awf [3], emp [3], aemp [3], ovf [3], unf [3];
    int         sel = 0, aw_lvl, ar_lvl, n_cmp = 0, n_bad = 0;
    bit         fwft;

    always #5 clk = ~clk;

    assign we = winc ? (3'b001 << sel) : 3'b000;
    assign rs = rinc ? (3'b001 << sel) : 3'b000;

    helai_sync_fifo #(.AW_LEVEL(12), .AR_LEVEL(3)) u_dist (
        .clk(clk), .rst(rst), .flush(flush), .winc(we[0]), .wdata(wdata), .wfull(wf[0]),
        .awfull(awf[0]), .rinc(rs[0]), .rdata(rd[0]), .rempty(emp[0]), .arempty(aemp[0]),
        .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0]));
    helai_sync_fifo #(.TYPE("block")) u_blk (
        .clk(clk), .rst(rst), .flush(flush), .winc(we[1]), .wdata(wdata), .wfull(wf[1]),
        .awfull(awf[1]), .rinc(rs[1]), .rdata(rd[1]), .rempty(emp[1]), .arempty(aemp[1]),
        .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1]));
    helai_sync_fifo #(.FALLTHROUGH("FALSE"), .AW_LEVEL(12), .AR_LEVEL(3)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .winc(we[2]), .wdata(wdata), .wfull(wf[2]),
        .awfull(awf[2]), .rinc(rs[2]), .rdata(rd[2]), .rempty(emp[2]), .arempty(aemp[2]),
        .count(cnt[2]), .overflow(ovf[2]), .underflow(unf[2]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[mode %0d]: got %0h, expected %0h", tag, sel, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_count"}, cnt[sel], 0);
        check({tag, "_wfull"}, wf[sel], 0);
        check({tag, "_awfull"}, awf[sel], 0);
        check({tag, "_rempty"}, emp[sel], 1);
        check({tag, "_arempty"}, aemp[sel], 1);
        check({tag, "_rdata"}, rd[sel], 0);
        check({tag, "_ovf"}, ovf[sel], 0);
        check({tag, "_unf"}, unf[sel], 0);
    endtask

    task automatic do_flush;
        flush = 1;
        tick;
        flush = 0;
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        winc = 1;
        for (int i = 0; i < n; i++) begin
            wdata = base + 8'(i);
            tick;
        end
        winc = 0;
    endtask

    task automatic run_mode;
        logic [7:0] q [$];
        logic [7:0] e;
        int nw;
        bit do_rd;
        fwft   = sel != 2;
        aw_lvl = sel == 1 ? 15 : 12;
        ar_lvl = sel == 1 ? 1 : 3;
        rst = 1;
        tick;
        rst = 0;
        check_reset("reset");
        winc = 1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(i);
            tick;
            check("fill_count", cnt[sel], i + 1);
            check("fill_awfull", awf[sel], i + 1 >= aw_lvl);
            check("fill_arempty", aemp[sel], i + 1 <= ar_lvl);
        end
        check("full_wfull", wf[sel], 1);
        wdata = 8'hEE;
        tick;
        winc = 0;
        check("ovf_count", cnt[sel], 16);
        check("ovf_flag", ovf[sel], 1);
        rinc = 1;
        for (int i = 0; i < 16; i++) begin
            if (fwft) begin
                check("drain_rempty", emp[sel], 0);
                check("drain_data", rd[sel], i);
            end
            tick;
            if (!fwft) check("drain_data", rd[sel], i);
            check("drain_count", cnt[sel], 15 - i);
            check("drain_awfull", awf[sel], 15 - i >= aw_lvl);
            check("drain_arempty", aemp[sel], 15 - i <= ar_lvl);
        end
        rinc = 0;
        check("drained_rempty", emp[sel], 1);
        rinc = 1;
        tick;
        rinc = 0;
        check("unf_flag", unf[sel], 1);
        check("unf_ovf_sticky", ovf[sel], 1);
        check("unf_count", cnt[sel], 0);
        do_flush;
        check("flush_ovf", ovf[sel], 0);
        check("flush_unf", unf[sel], 0);
        check("flush_count", cnt[sel], 0);
        check("flush_rdata", rd[sel], 0);
        fill(8'h20, 5);
        winc = 1;
        rinc = 1;
        wdata = 8'h25;
        tick;
        winc = 0;
        rinc = 0;
        check("sim5_count", cnt[sel], 5);
        check("sim5_data", rd[sel], fwft ? 8'h21 : 8'h20);
        do_flush;
        fill(8'h30, 16);
        winc = 1;
        rinc = 1;
        wdata = 8'h99;
        tick;
        winc = 0;
        rinc = 0;
        check("simfull_count", cnt[sel], 15);
        check("simfull_ovf", ovf[sel], 1);
        check("simfull_data", rd[sel], fwft ? 8'h31 : 8'h30);
        do_flush;
        winc = 1;
        rinc = 1;
        wdata = 8'h55;
        tick;
        winc = 0;
        rinc = 0;
        check("simempty_count", cnt[sel], 1);
        check("simempty_unf", unf[sel], 1);
        do_flush;
        fill(8'hA5, 1);
        if (sel == 1) begin
            check("lat_blk_rempty1", emp[sel], 1);
            check("lat_blk_count1", cnt[sel], 1);
            tick;
        end
        check("lat_rempty", emp[sel], 0);
        if (fwft) check("lat_data", rd[sel], 8'hA5);
        rinc = 1;
        tick;
        rinc = 0;
        if (!fwft) check("lat_data", rd[sel], 8'hA5);
        check("lat_empty_after", emp[sel], 1);
        nw = 0;
        for (int c = 0; c < 300 && (nw < 40 || q.size() > 0); c++) begin
            winc  = nw < 40 && !wf[sel];
            wdata = 8'h40 + 8'(nw);
            rinc  = (c % 3 != 0 || nw >= 40) && !emp[sel];
            do_rd = rinc;
            if (fwft && do_rd) check("wrap_data", rd[sel], q[0]);
            tick;
            if (winc) begin
                q.push_back(wdata);
                nw++;
            end
            if (do_rd) begin
                e = q.pop_front();
                if (!fwft) check("wrap_data", rd[sel], e);
            end
        end
        winc = 0;
        rinc = 0;
        check("wrap_done", nw == 40 && q.size() == 0, 1);
        check("wrap_rempty", emp[sel], 1);
        fill(8'h70, 3);
        winc = 1;
        rinc = 1;
        rst = 1;
        tick;
        rst = 0;
        winc = 0;
        rinc = 0;
        check_reset("midrst");
    endtask

    initial begin
        tick;
        for (int m = 0; m < 3; m++) begin
            sel = m;
            run_mode();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
